// File: rtl/approx_error_monitor.sv
// Accuracy monitor for the hybrid approximate adder: error distance per pair,
// accumulated into error-rate / error-distance statistics over a programmed run.
module approx_error_monitor #(
    parameter int unsigned N1    = 16,
    parameter int unsigned N2    = 16,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N1+N2-1:0]   approx_sum,
    input  logic               approx_cout,
    input  logic [N1+N2:0]     exact_sum,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [N1+N2:0]     max_ed,
    output logic [ACC_W-1:0]   sum_ed,
    output logic               sum_ed_sat
);

    localparam int unsigned W  = N1 + N2;
    localparam int unsigned EW = W + 1;
    // Wide enough to hold accumulator + one ED without wrapping
    localparam int unsigned SW = ((ACC_W > EW) ? ACC_W : EW) + 1;
    localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               s1_vld_q, s1_vld_d;
    logic [EW-1:0]      s1_ed_q, s1_ed_d;
    logic               s1_nz_q, s1_nz_d;
    logic [CNT_W-1:0]   sample_count_q, sample_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [EW-1:0]      max_ed_q, max_ed_d;
    logic [ACC_W-1:0]   sum_ed_q, sum_ed_d;
    logic               sum_ed_sat_q, sum_ed_sat_d;

    logic [EW-1:0]      approx_c;
    logic [EW-1:0]      ed_c;
    logic               accept_c;
    logic [SW-1:0]      sum_wide_c;

    // Error distance: subtract smaller from larger so it never wraps
    always_comb begin
        approx_c   = {approx_cout, approx_sum};
        ed_c       = (exact_sum >= approx_c) ? (exact_sum - approx_c)
                                             : (approx_c - exact_sum);
        accept_c   = (state_q == S_RUN) && in_valid && in_ready_q;
        sum_wide_c = SW'(sum_ed_q) + SW'(s1_ed_q);
    end

    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        acc_cnt_d      = acc_cnt_q;
        s1_vld_d       = 1'b0;
        s1_ed_d        = s1_ed_q;
        s1_nz_d        = s1_nz_q;
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        max_ed_d       = max_ed_q;
        sum_ed_d       = sum_ed_q;
        sum_ed_sat_d   = sum_ed_sat_q;

        // Stage 2: fold the retiring stage-1 sample into the statistics
        if (s1_vld_q) begin
            sample_count_d = sample_count_q + CNT_W'(1);
            if (s1_nz_q) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
            if (s1_ed_q > max_ed_q) begin
                max_ed_d = s1_ed_q;
            end
            if (sum_wide_c > ACC_MAX) begin
                sum_ed_d     = {ACC_W{1'b1}};
                sum_ed_sat_d = 1'b1;
            end else begin
                sum_ed_d = sum_wide_c[ACC_W-1:0];
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sample_count_d = '0;
                    err_count_d    = '0;
                    max_ed_d       = '0;
                    sum_ed_d       = '0;
                    sum_ed_sat_d   = 1'b0;
                    num_d          = num_samples;
                    acc_cnt_d      = '0;
                    state_d        = (num_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept_c) begin
                    s1_vld_d  = 1'b1;
                    s1_ed_d   = ed_c;
                    s1_nz_d   = (ed_c != '0);
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == (num_q - CNT_W'(1))) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags follow the next state so they are registered with it
        in_ready_d = (state_d == S_RUN);
        busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            num_q          <= '0;
            acc_cnt_q      <= '0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            s1_vld_q       <= 1'b0;
            s1_ed_q        <= '0;
            s1_nz_q        <= 1'b0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            max_ed_q       <= '0;
            sum_ed_q       <= '0;
            sum_ed_sat_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            acc_cnt_q      <= acc_cnt_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            s1_vld_q       <= s1_vld_d;
            s1_ed_q        <= s1_ed_d;
            s1_nz_q        <= s1_nz_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            max_ed_q       <= max_ed_d;
            sum_ed_q       <= sum_ed_d;
            sum_ed_sat_q   <= sum_ed_sat_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign max_ed       = max_ed_q;
    assign sum_ed       = sum_ed_q;
    assign sum_ed_sat   = sum_ed_sat_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: directed scenarios plus random runs against a
// queue-based reference model; a second instance with an 8-bit accumulator covers saturation.
module tb_approx_error_monitor;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned ACC_W = 48;
    localparam longint MAX48 = 64'hFFFF_FFFF_FFFF;
    localparam longint MAX8  = 64'hFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_samples = '0;
    logic        in_valid = 1'b0;
    logic [31:0] approx_sum = '0;
    logic        approx_cout = 1'b0;
    logic [32:0] exact_sum = '0;

    logic        in_ready, busy, done, sum_ed_sat;
    logic [15:0] sample_count, err_count;
    logic [32:0] max_ed;
    logic [47:0] sum_ed;

    logic        in_ready8, busy8, done8, sum_ed_sat8;
    logic [15:0] sample_count8, err_count8;
    logic [32:0] max_ed8;
    logic [7:0]  sum_ed8;

    approx_error_monitor dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .approx_sum(approx_sum),
        .approx_cout(approx_cout), .exact_sum(exact_sum), .busy(busy), .done(done),
        .sample_count(sample_count), .err_count(err_count), .max_ed(max_ed),
        .sum_ed(sum_ed), .sum_ed_sat(sum_ed_sat)
    );

    approx_error_monitor #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready8), .approx_sum(approx_sum),
        .approx_cout(approx_cout), .exact_sum(exact_sum), .busy(busy8), .done(done8),
        .sample_count(sample_count8), .err_count(err_count8), .max_ed(max_ed8),
        .sum_ed(sum_ed8), .sum_ed_sat(sum_ed_sat8)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 run, 2 drain, 3 done; accepted EDs in a queue,
    // of which the first m_vis are reflected in the statistics
    int     m_phase = 0;
    int     m_num = 0;
    int     m_acc = 0;
    int     m_vis = 0;
    longint m_eds[$];

    function automatic longint ed_of(input logic [32:0] apx, input logic [32:0] ex);
        longint a;
        longint e;
        a = 64'(apx);
        e = 64'(ex);
        return (a > e) ? (a - e) : (e - a);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_num   = 0;
        m_acc   = 0;
        m_vis   = 0;
        m_eds.delete();
    endtask

    task automatic model_edge(input logic st, input int n, input logic v, input longint ed);
        bit acc;
        m_vis = m_eds.size();
        acc = (m_phase == 1) && v;
        if (acc) m_eds.push_back(ed);
        case (m_phase)
            0, 3: if (st) begin
                m_eds.delete();
                m_vis   = 0;
                m_num   = n & 32'hFFFF;
                m_acc   = 0;
                m_phase = (m_num == 0) ? 3 : 1;
            end
            1: if (acc) begin
                m_acc++;
                if (m_acc == m_num) m_phase = 2;
            end
            default: m_phase = 3;
        endcase
    endtask

    task automatic check_all();
        longint tot;
        longint mx;
        int     err;
        tot = 0;
        mx  = 0;
        err = 0;
        for (int i = 0; i < m_vis; i++) begin
            tot += m_eds[i];
            if (m_eds[i] != 0) err++;
            if (m_eds[i] > mx) mx = m_eds[i];
        end
        chk("in_ready",     64'(in_ready),     64'(m_phase == 1));
        chk("busy",         64'(busy),         64'(m_phase == 1 || m_phase == 2));
        chk("done",         64'(done),         64'(m_phase == 3));
        chk("sample_count", 64'(sample_count), 64'(m_vis));
        chk("err_count",    64'(err_count),    64'(err));
        chk("max_ed",       64'(max_ed),       64'(mx));
        chk("sum_ed",       64'(sum_ed),       64'((tot > MAX48) ? MAX48 : tot));
        chk("sum_ed_sat",   64'(sum_ed_sat),   64'(tot > MAX48));
        chk("done8",        64'(done8),        64'(m_phase == 3));
        chk("max_ed8",      64'(max_ed8),      64'(mx));
        chk("sum_ed8",      64'(sum_ed8),      64'((tot > MAX8) ? MAX8 : tot));
        chk("sum_ed_sat8",  64'(sum_ed_sat8),  64'(tot > MAX8));
    endtask

    // One clock: drive inputs, advance model at the edge, check just after it
    task automatic cyc(input logic st, input int n, input logic v,
                       input logic [32:0] apx, input logic [32:0] ex);
        start       = st;
        num_samples = 16'(n);
        in_valid    = v;
        approx_sum  = apx[31:0];
        approx_cout = apx[32];
        exact_sum   = ex;
        @(posedge clk);
        model_edge(st, n, v, ed_of(apx, ex));
        #1;
        check_all();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 0, 1'b0, 33'd0, 33'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    function automatic logic [32:0] rnd_exact();
        logic [32:0] a;
        logic [32:0] b;
        a = {1'b0, 32'($urandom)};
        b = {1'b0, 32'($urandom)};
        return a + b;
    endfunction

    function automatic logic [32:0] rnd_approx(input logic [32:0] ex);
        logic [32:0] r;
        case ($urandom_range(0, 3))
            0: r = ex;
            1: r = {ex[32:16], 16'($urandom)};
            2: r = ex ^ (33'd1 << $urandom_range(0, 32));
            default: r = {1'($urandom), 32'($urandom)};
        endcase
        return r;
    endfunction

    task automatic run_random(input int n, input int gap_pct);
        int budget;
        logic [32:0] e;
        cyc(1'b1, n, 1'b0, 33'd0, 33'd0);
        budget = 4 * n + 20;
        while (m_phase != 3 && budget > 0) begin
            e = rnd_exact();
            cyc(1'($urandom_range(0, 19) == 0), int'($urandom_range(0, 50)),
                1'($urandom_range(0, 99) >= gap_pct), rnd_approx(e), e);
            budget--;
        end
        chk("rand_done", 64'(done), 64'd1);
        chk("rand_cnt",  64'(sample_count), 64'(n));
    endtask

    initial begin
        // Reset state
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();

        // Exact stream
        cyc(1'b1, 20, 1'b0, 33'd0, 33'd0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 0, 1'b1, 33'h0AE321083, 33'h0AE321083);
        idle(2);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_cnt",  64'(sample_count), 64'd20);
        chk("t1_err",  64'(err_count), 64'd0);
        chk("t1_sum",  64'(sum_ed), 64'd0);

        // Single error, approx below exact across the carry boundary
        cyc(1'b1, 5, 1'b0, 33'd0, 33'd0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 0, 1'b1, 33'h012345678, 33'h012345678);
        cyc(1'b0, 0, 1'b1, 33'h0FFFFFFFF, 33'h100000000);
        for (int i = 0; i < 2; i++) cyc(1'b0, 0, 1'b1, 33'h012345678, 33'h012345678);
        idle(2);
        chk("t2_err", 64'(err_count), 64'd1);
        chk("t2_max", 64'(max_ed), 64'd1);
        chk("t2_sum", 64'(sum_ed), 64'd1);

        // Single error, approx above exact
        cyc(1'b1, 5, 1'b0, 33'd0, 33'd0);
        cyc(1'b0, 0, 1'b1, 33'h012350000, 33'h012340000);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 33'h1ABCD0001, 33'h1ABCD0001);
        idle(2);
        chk("t2b_err", 64'(err_count), 64'd1);
        chk("t2b_max", 64'(max_ed), 64'h10000);
        chk("t2b_sum", 64'(sum_ed), 64'h10000);

        // Latency / handshake with gaps and a dropped 4th valid
        cyc(1'b1, 3, 1'b0, 33'd0, 33'd0);
        cyc(1'b0, 0, 1'b1, 33'd7, 33'd9);
        cyc(1'b0, 0, 1'b0, 33'd0, 33'd0);
        cyc(1'b0, 0, 1'b1, 33'd7, 33'd7);
        idle(2);
        cyc(1'b0, 0, 1'b1, 33'd100, 33'd90);
        chk("t3_ready_low", 64'(in_ready), 64'd0);
        chk("t3_done_k0",   64'(done), 64'd0);
        cyc(1'b0, 0, 1'b1, 33'd0, 33'h1000);
        chk("t3_done_k1",   64'(done), 64'd1);
        chk("t3_cnt",       64'(sample_count), 64'd3);
        chk("t3_max",       64'(max_ed), 64'd10);

        // Zero-sample run, then start pulse during RUN
        cyc(1'b1, 0, 1'b0, 33'd0, 33'd0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_cnt",  64'(sample_count), 64'd0);
        chk("t4_sum",  64'(sum_ed), 64'd0);
        cyc(1'b1, 6, 1'b0, 33'd0, 33'd0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 0, 1'b1, 33'd5, 33'd3);
        cyc(1'b1, 9, 1'b1, 33'd5, 33'd3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 33'd5, 33'd3);
        idle(2);
        chk("t4_cnt6", 64'(sample_count), 64'd6);
        chk("t4_sum6", 64'(sum_ed), 64'd12);

        // Saturation of the 8-bit accumulator
        cyc(1'b1, 4, 1'b0, 33'd0, 33'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 33'h0B0, 33'h100);
        idle(2);
        chk("t5_sum8", 64'(sum_ed8), 64'hFF);
        chk("t5_sat8", 64'(sum_ed_sat8), 64'd1);
        chk("t5_max8", 64'(max_ed8), 64'h50);
        chk("t5_sum",  64'(sum_ed), 64'h140);

        // Reset mid-run after 7 of 10 accepts
        cyc(1'b1, 10, 1'b0, 33'd0, 33'd0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 0, 1'b1, 33'd1, 33'd4);
        do_reset();
        chk("t6_cnt0",  64'(sample_count), 64'd0);
        chk("t6_busy0", 64'(busy), 64'd0);
        cyc(1'b1, 2, 1'b0, 33'd0, 33'd0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 0, 1'b1, 33'd1, 33'd4);
        idle(2);
        chk("t6_cnt2", 64'(sample_count), 64'd2);

        // Random runs
        for (int r = 0; r < 12; r++) run_random(int'($urandom_range(1, 40)), int'($urandom_range(0, 50)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
